// File: rtl/queue_uart_tx_pkg.sv
// Shared types and constants for the queue-draining UART transmitter and its baud helper.
package queue_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int unsigned CLK_DIV_DEFAULT = 434;
  localparam logic        IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module uart_baud_tick
  import queue_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic m_clock,
  input  logic p_reset,
  input  logic clear_i,
  output logic tick_o
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/queue_uart_tx.sv
// Pops bytes from the queue and serialises them LSB first onto txd (8N1).
// Build with PARITY_EN defined for 8E1 frames (even parity bit after the data bits).
module queue_uart_tx
  import queue_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              m_clock,
  input  logic              p_reset,
  input  logic [DATA_W-1:0] q_data,
  input  logic              q_is_empty,
  output logic              q_pop,
  output logic              txd,
  output logic              busy
);

  localparam int unsigned   IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     bit_q, bit_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              tick;
`ifdef PARITY_EN
  logic              par_q, par_d;
`endif

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .clear_i (state_q == IDLE),
    .tick_o  (tick)
  );

  // The queue shows its front entry combinationally, so capture happens in the pop cycle.
  assign q_pop = (state_q == IDLE) & ~q_is_empty & p_reset;
  assign txd   = txd_q;
  assign busy  = busy_q;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      txd_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (q_pop) begin
        state_d = START;
        shift_d = q_data;
`ifdef PARITY_EN
        par_d   = ^q_data;
`endif
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + IW'(1);
        if (bit_q == LAST_BIT) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY:  if (tick) state_d = STOP;
      STOP:    if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // txd is registered, so it is derived from the state being entered.
  always_comb begin
    txd_d = IDLE_LEVEL;
    case (state_d)
      START: txd_d = 1'b0;
      DATA:  txd_d = shift_d[0];
`ifdef PARITY_EN
      PARITY: txd_d = par_d;
`endif
      default: txd_d = IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

`ifndef SYNTHESIS
  always_ff @(posedge m_clock) begin
    assert (CLK_DIV >= 2) else $error("queue_uart_tx: CLK_DIV must be at least 2");
  end
`endif

endmodule

// File: tb/tb_queue_uart_tx.sv
// Bench for queue_uart_tx: queue model, line receiver with scoreboard, scenario tasks.
`timescale 1ns/1ps
module tb_queue_uart_tx;

  localparam int DIV = 4;
  localparam int DW  = 8;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] q_data = 8'h00;
  logic       q_is_empty = 1'b1;
  logic       q_pop, txd, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit         pop_pending = 1'b0;

  queue_uart_tx #(.CLK_DIV(DIV), .DATA_W(DW)) dut (
    .m_clock    (clk),
    .p_reset    (rst_n),
    .q_data     (q_data),
    .q_is_empty (q_is_empty),
    .q_pop      (q_pop),
    .txd        (txd),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level t cycles after the first start-bit cycle.
  function automatic logic frame_bit(input logic [7:0] b, input int t);
    int k;
    k = t / DIV;
    if (k == 0) return 1'b0;
    if (k <= DW) return b[k-1];
`ifdef PARITY_EN
    if (k == DW + 1) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (q_pop === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Queue model: front entry visible combinationally; removed after the DUT pops it.
  initial begin : feeder
    forever begin
      @(negedge clk);
      if (pop_pending) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        pop_pending = 1'b0;
      end
      q_is_empty = (src_q.size() == 0);
      q_data     = (src_q.size() > 0) ? src_q[0] : 8'h00;
      #1;
      if (q_pop === 1'b1) pop_pending = 1'b1;
    end
  end

  // Line receiver: decodes each frame mid-bit and checks it against the scoreboard.
  initial begin : receiver
    logic [NB-1:0] bits;
    logic [7:0]    exp_b;
    bit            aborted;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1 && txd === 1'b0) begin
        bits    = '0;
        aborted = 1'b0;
        for (int t = 1; t <= (NB - 1) * DIV + DIV / 2; t++) begin
          @(negedge clk);
          #3;
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (t % DIV == DIV / 2) bits[t / DIV] = txd;
        end
        if (!aborted) begin
          n_checks++;
          if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_framing: start=%b stop=%b, expected start=0 stop=1", bits[0], bits[NB-1]);
          end
`ifdef PARITY_EN
          n_checks++;
          if (bits[DW+1] !== ^bits[DW:1]) begin
            n_fail++;
            $display("FAIL rx_parity: got %b for data %h, expected %b", bits[DW+1], bits[DW:1], ^bits[DW:1]);
          end
`endif
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected: received %h, expected no frame", bits[DW:1]);
          end else begin
            exp_b = exp_q.pop_front();
            if (bits[DW:1] !== exp_b) begin
              n_fail++;
              $display("FAIL rx_data: received %h, expected %h", bits[DW:1], exp_b);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    src_q.push_back(8'h11);
    repeat (3) step();
    n_checks++;
    if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b, expected 1", txd); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_checks++;
    if (q_pop !== 1'b0) begin n_fail++; $display("FAIL reset_pop: got %b, expected 0 with queue non-empty", q_pop); end
    src_q.delete();
    repeat (2) step();
    release_reset();
    step();
    n_checks++;
    if ({txd, busy, q_pop} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: txd/busy/q_pop got %b, expected 100", {txd, busy, q_pop});
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad, bad_t;
    logic bad_txd, bad_busy, pop_after;
    logic [7:0] b;
    b = 8'hA5;
    src_q.push_back(b);
    exp_q.push_back(b);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_pop: q_pop got 0, expected 1 within 60 cycles"); end
    if (ok) begin
      bad = 0; bad_t = 0; bad_txd = 1'b0; bad_busy = 1'b0; pop_after = 1'b0;
      for (int t = 0; t < FRAME; t++) begin
        step();
        if (t == 0) pop_after = q_pop;
        if (txd !== frame_bit(b, t) || busy !== 1'b1) begin
          if (bad == 0) begin bad_t = t; bad_txd = txd; bad_busy = busy; end
          bad++;
        end
      end
      n_checks++;
      if (pop_after !== 1'b0) begin n_fail++; $display("FAIL single_pop_width: q_pop got %b after pop cycle, expected 0", pop_after); end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL single_wave: %0d bad cycles, first t=%0d txd=%b busy=%b, expected txd=%b busy=1",
                 bad, bad_t, bad_txd, bad_busy, frame_bit(b, bad_t));
      end
      step();
      n_checks++;
      if ({txd, busy} !== 2'b10) begin n_fail++; $display("FAIL single_end: txd/busy got %b, expected 10", {txd, busy}); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p1, bad, bad_t;
    logic [7:0] b0, b1;
    b0 = 8'h00;
    b1 = 8'hFF;
    src_q.push_back(b0); exp_q.push_back(b0);
    src_q.push_back(b1); exp_q.push_back(b1);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_pop: q_pop got 0, expected 1 within 60 cycles"); end
    if (ok) begin
      p1 = cyc;
      bad = 0; bad_t = 0;
      for (int t = 0; t < 2 * FRAME + 2; t++) begin
        step();
        if (t < FRAME) begin
          if (txd !== frame_bit(b0, t) || busy !== 1'b1) begin if (bad == 0) bad_t = t; bad++; end
        end else if (t == FRAME || t == 2 * FRAME + 1) begin
          if (txd !== 1'b1 || busy !== 1'b0) begin if (bad == 0) bad_t = t; bad++; end
          if (t == FRAME) begin
            n_checks++;
            if (q_pop !== 1'b1 || cyc - p1 != FRAME + 1) begin
              n_fail++;
              $display("FAIL b2b_gap: q_pop=%b at %0d cycles after first pop, expected 1 at %0d", q_pop, cyc - p1, FRAME + 1);
            end
          end
        end else begin
          if (txd !== frame_bit(b1, t - FRAME - 1) || busy !== 1'b1) begin if (bad == 0) bad_t = t; bad++; end
        end
      end
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_wave: %0d bad cycles, first t=%0d, expected 0 bad", bad, bad_t); end
    end
  endtask

  task automatic test_empty();
    int pops, txd_low, busy_hi;
    pops = 0; txd_low = 0; busy_hi = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (q_pop !== 1'b0) pops++;
      if (txd !== 1'b1) txd_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    n_checks++;
    if (pops != 0) begin n_fail++; $display("FAIL empty_pop: %0d pop cycles, expected 0", pops); end
    n_checks++;
    if (txd_low != 0) begin n_fail++; $display("FAIL empty_txd: %0d non-idle cycles, expected 0", txd_low); end
    n_checks++;
    if (busy_hi != 0) begin n_fail++; $display("FAIL empty_busy: %0d busy cycles, expected 0", busy_hi); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int pops, bad, bad_t;
    logic [7:0] b;
    src_q.push_back(8'h3C);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rmid_pop: q_pop got 0, expected 1 within 60 cycles"); end
    if (ok) begin
      repeat (4 * DIV + 1) step();
      n_checks++;
      if ({busy, txd} !== {1'b1, frame_bit(8'h3C, 4 * DIV)}) begin
        n_fail++;
        $display("FAIL rmid_bit3: busy/txd got %b, expected 1%b", {busy, txd}, frame_bit(8'h3C, 4 * DIV));
      end
      b = 8'h5A;
      src_q.push_back(b);
      exp_q.push_back(b);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({txd, busy} !== 2'b10) begin n_fail++; $display("FAIL rmid_async: txd/busy got %b, expected 10", {txd, busy}); end
      pops = 0;
      repeat (3) begin
        step();
        if (q_pop !== 1'b0) pops++;
      end
      n_checks++;
      if (pops != 0) begin n_fail++; $display("FAIL rmid_nopop: %0d pops during reset, expected 0", pops); end
      release_reset();
      wait_pop(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rmid_repop: q_pop got 0, expected 1 after release"); end
      if (ok) begin
        bad = 0; bad_t = 0;
        for (int t = 0; t < FRAME; t++) begin
          step();
          if (txd !== frame_bit(b, t) || busy !== 1'b1) begin if (bad == 0) bad_t = t; bad++; end
        end
        step();
        n_checks++;
        if (bad != 0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rmid_fresh: %0d bad cycles (first t=%0d), busy after=%b, expected 0 bad and busy 0", bad, bad_t, busy);
        end
      end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    bit ok;
    int bad, busy_cnt;
    logic par_seen, par_exp;
    logic [7:0] b;
    for (int i = 0; i < 2; i++) begin
      b       = (i == 0) ? 8'h07 : 8'h03;
      par_exp = (i == 0) ? 1'b1 : 1'b0;
      src_q.push_back(b);
      exp_q.push_back(b);
      wait_pop(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL parity_pop: q_pop got 0 for %h, expected 1", b); end
      if (ok) begin
        bad = 0; busy_cnt = 0; par_seen = 1'bx;
        for (int t = 0; t < FRAME + 1; t++) begin
          step();
          if (busy === 1'b1) busy_cnt++;
          if (t == (DW + 1) * DIV + DIV / 2) par_seen = txd;
          if (t < FRAME && txd !== frame_bit(b, t)) bad++;
        end
        n_checks++;
        if (par_seen !== par_exp) begin n_fail++; $display("FAIL parity_bit: got %b for %h, expected %b", par_seen, b, par_exp); end
        n_checks++;
        if (busy_cnt != 44 || bad != 0) begin
          n_fail++;
          $display("FAIL parity_frame: busy %0d cycles with %0d bad bits, expected 44 and 0", busy_cnt, bad);
        end
      end
    end
  endtask
`endif

  task automatic test_refill_in_stop();
    bit ok;
    int p1, early;
    src_q.push_back(8'h81);
    exp_q.push_back(8'h81);
    wait_pop(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL refill_pop1: q_pop got 0, expected 1"); end
    if (ok) begin
      p1 = cyc;
      early = 0;
      for (int t = 0; t <= (NB - 1) * DIV + 1; t++) begin
        step();
        if (q_pop !== 1'b0) early++;
      end
      src_q.push_back(8'h42);
      exp_q.push_back(8'h42);
      step();
      n_checks++;
      if ({q_is_empty, q_pop, busy} !== 3'b001 || early != 0) begin
        n_fail++;
        $display("FAIL refill_stop: empty/pop/busy got %b with %0d early pops, expected 001 and 0", {q_is_empty, q_pop, busy}, early);
      end
      wait_pop(ok);
      n_checks++;
      if (!ok || cyc - p1 != FRAME + 1 || txd !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL refill_idle_pop: pop ok=%b at %0d cycles (txd=%b busy=%b), expected %0d on idle cycle",
                 ok, cyc - p1, txd, busy, FRAME + 1);
      end
      repeat (FRAME + 1) step();
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain: %0d frames never received, expected 0", exp_q.size()); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
`ifdef PARITY_EN
    test_parity();
`endif
    test_refill_in_stop();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
